// File: rtl/fir_pkg.sv
// Shared types and defaults for the time-multiplexed FIR controller.
// Also holds the helper that sizes the accumulator so it cannot overflow.
package fir_pkg;

  localparam int DEF_NTAPS = 4;
  localparam int DEF_DW    = 8;
  localparam int DEF_CW    = 8;
  localparam int DEF_OW    = 16;

  // coef[0] sits at the LSBs: coef = {-2, -1, 3, 4} for taps 0..3
  localparam logic [DEF_NTAPS*DEF_CW-1:0] DEF_COEF_INIT = 32'h0403_FFFE;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_e;

  function automatic int acc_width(input int ntaps, input int dw, input int cw);
    return dw + cw + $clog2(ntaps);
  endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// Shared signed multiply-accumulate: acc <= acc + coef*data when enabled.
// The clear input wins over enable so a new sample always starts from zero.
module fir_mac_unit
  import fir_pkg::*;
#(
  parameter int CW = DEF_CW,
  parameter int DW = DEF_DW,
  parameter int AW = acc_width(DEF_NTAPS, DEF_DW, DEF_CW)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clr_i,
  input  logic                 en_i,
  input  logic signed [CW-1:0] coef_i,
  input  logic signed [DW-1:0] data_i,
  output logic signed [AW-1:0] acc_o
);

  logic signed [CW+DW-1:0] prod;
  logic signed [AW-1:0]    acc_q, acc_d;

  assign prod = coef_i * data_i;

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + AW'(prod);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/fir_mac_sched.sv
// FIR controller that walks one shared MAC across NTAPS taps per sample.
// Handshakes: a transfer happens on a rising clock edge where valid and ready are both high.
module fir_mac_sched
  import fir_pkg::*;
#(
  parameter int                    NTAPS     = DEF_NTAPS,
  parameter int                    DW        = DEF_DW,
  parameter int                    CW        = DEF_CW,
  parameter int                    OW        = DEF_OW,
  parameter logic [NTAPS*CW-1:0]   COEF_INIT = DEF_COEF_INIT,
  localparam int                   ADW       = $clog2(NTAPS)
) (
  input  logic           Clk,
  input  logic           Rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [DW-1:0]  in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [OW-1:0]  out_data,
  input  logic           cfg_we,
  input  logic [ADW-1:0] cfg_addr,
  input  logic [CW-1:0]  cfg_data,
  output logic           cfg_err,
  output logic           busy,
  output state_e         dbg_state
);

  localparam int              AW       = acc_width(NTAPS, DW, CW);
  localparam int              TW       = $clog2(NTAPS + 1);
  localparam logic [TW-1:0]   TAP_LAST = TW'(NTAPS);
  localparam logic [ADW:0]    NTAPS_W  = (ADW + 1)'(NTAPS);

  state_e               state_q, state_d;
  logic [TW-1:0]        tap_q, tap_d;
  logic signed [DW-1:0] x_q    [NTAPS];
  logic signed [CW-1:0] coef_q [NTAPS];
  logic [OW-1:0]        out_data_q;
  logic                 cfg_err_q;

  logic                 accept;
  logic                 mac_clr;
  logic                 mac_en;
  logic                 out_load;
  logic                 cfg_hit;
  logic [ADW-1:0]       tap_idx;
  logic signed [AW-1:0] acc;

  // MAC runs NTAPS accumulate cycles, then one more cycle to hand the sum to out_data.
  always_comb begin
    state_d  = state_q;
    tap_d    = tap_q;
    mac_clr  = 1'b0;
    mac_en   = 1'b0;
    out_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = MAC;
          tap_d   = '0;
          mac_clr = 1'b1;
        end
      end
      MAC: begin
        if (tap_q == TAP_LAST) begin
          state_d  = OUT;
          out_load = 1'b1;
        end else begin
          mac_en = 1'b1;
          tap_d  = tap_q + TW'(1);
        end
      end
      OUT: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      tap_q   <= '0;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
    end
  end

  assign accept  = (state_q == IDLE) && in_valid;
  assign tap_idx = tap_q[ADW-1:0];
  assign cfg_hit = cfg_we && (state_q == IDLE) && ({1'b0, cfg_addr} < NTAPS_W);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int k = 0; k < NTAPS; k++) x_q[k] <= '0;
    end else if (accept) begin
      x_q[0] <= in_data;
      for (int k = 1; k < NTAPS; k++) x_q[k] <= x_q[k-1];
    end
  end

  // A write landing with an accepted sample still counts: MAC reads coefficients a cycle later.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int k = 0; k < NTAPS; k++) coef_q[k] <= COEF_INIT[k*CW +: CW];
    end else if (cfg_hit) begin
      coef_q[cfg_addr] <= cfg_data;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      out_data_q <= '0;
      cfg_err_q  <= 1'b0;
    end else begin
      if (out_load) begin
        out_data_q <= OW'(acc);
      end
      cfg_err_q <= cfg_we && !cfg_hit;
    end
  end

  fir_mac_unit #(
    .CW (CW),
    .DW (DW),
    .AW (AW)
  ) u_mac (
    .clk_i  (Clk),
    .rst_ni (Rst_n),
    .clr_i  (mac_clr),
    .en_i   (mac_en),
    .coef_i (coef_q[tap_idx]),
    .data_i (x_q[tap_idx]),
    .acc_o  (acc)
  );

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == OUT);
  assign busy      = (state_q != IDLE);
  assign out_data  = out_data_q;
  assign cfg_err   = cfg_err_q;
  assign dbg_state = state_q;

endmodule
